// File: rtl/freq_mon_pkg.sv
// Shared types for the frequency-monitor scheduler: FSM states and the
// round-robin channel search helper.
package freq_mon_pkg;

  localparam int MAX_CH = 32;

  typedef enum logic [2:0] {
    IDLE, SELECT, SETTLE, START, MEASURE, RESULT, NEXT
  } state_t;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } ch_pick_t;

  // Lowest set mask bit strictly above cur; cur = -1 finds the lowest bit.
  function automatic ch_pick_t next_ch(input logic [MAX_CH-1:0] mask, input int cur);
    ch_pick_t r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && i > cur) begin
        r.found = 1'b1;
        r.idx   = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_monitor_sched_if.sv
// Scheduler <-> shared frequency comparator link: mux select, comparator
// control and the comparator's result/completion.
interface freq_monitor_sched_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32
);
  logic [$clog2(NUM_CH)-1:0] ch_sel;
  logic                      cmp_reset;
  logic                      cmp_enable;
  logic [DATA_WIDTH-1:0]     cmp_timeout_value;
  logic                      cmp_ge;
  logic                      cmp_done;

  modport master (output ch_sel, cmp_reset, cmp_enable, cmp_timeout_value,
                  input  cmp_ge, cmp_done);
  modport slave  (input  ch_sel, cmp_reset, cmp_enable, cmp_timeout_value,
                  output cmp_ge, cmp_done);
endinterface

// File: rtl/freq_mon_debounce.sv
// One channel's consecutive-fail counter plus sticky fail/dead flags.
// FREQ_MON_SCHED_IRQ_EN adds a rise output marking a flag's 0->1 event.
module freq_mon_debounce #(
  parameter int FAIL_THRESH = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic fail_ev,
  input  logic pass_ev,
  input  logic dead_ev,
  input  logic clear,
  output logic fail,
  output logic dead
`ifdef FREQ_MON_SCHED_IRQ_EN
  , output logic rise
`endif
);
  localparam int CW = $clog2(FAIL_THRESH + 1);

  logic [CW-1:0] cnt, cnt_inc;
  logic          fail_set;

  assign cnt_inc  = (cnt == CW'(FAIL_THRESH)) ? cnt : cnt + 1'b1;
  // Judged on the pre-clear count so a coincident clear cannot mask a set.
  assign fail_set = fail_ev && (cnt_inc == CW'(FAIL_THRESH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      fail <= 1'b0;
      dead <= 1'b0;
    end else begin
      if (fail_ev)               cnt <= clear ? CW'(1) : cnt_inc;
      else if (pass_ev || clear) cnt <= '0;
      if (fail_set)   fail <= 1'b1;
      else if (clear) fail <= 1'b0;
      if (dead_ev)    dead <= 1'b1;
      else if (clear) dead <= 1'b0;
    end
  end

`ifdef FREQ_MON_SCHED_IRQ_EN
  assign rise = (fail_set && (!fail || clear)) || (dead_ev && (!dead || clear));
`endif
endmodule

// File: rtl/freq_monitor_sched.sv
// Round-robin scheduler sharing one frequency comparator across NUM_CH clocks.
// Optional FREQ_MON_SCHED_IRQ_EN adds a sticky irq on any new fail/dead flag.
module freq_monitor_sched
  import freq_mon_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 16,
  parameter int WDOG_WIDTH    = 24,
  parameter int FAIL_THRESH   = 3,
  parameter int MIN_WINDOW    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic [NUM_CH-1:0]     ch_mask,
  input  logic [DATA_WIDTH-1:0] window,
  input  logic [WDOG_WIDTH-1:0] wdog_limit,
  input  logic [NUM_CH-1:0]     fail_clear,
  freq_monitor_sched_if.master  cmp,
  output logic [NUM_CH-1:0]     ch_fail,
  output logic [NUM_CH-1:0]     ch_dead,
  output logic                  sweep_done,
  output logic                  busy
`ifdef FREQ_MON_SCHED_IRQ_EN
  , output logic                irq
  , input  logic                irq_clear
`endif
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int SW    = $clog2(SETTLE_CYCLES + 1);

  state_t                state;
  logic [SEL_W-1:0]      sel;
  logic [SW-1:0]         settle;
  logic [WDOG_WIDTH-1:0] wdog;
  logic                  rst_q, en_q;
  logic [DATA_WIDTH-1:0] tv_q;
  logic [MAX_CH-1:0]     mask_ext;
  ch_pick_t              first, nxt;
  logic                  rec, wdog_hit;

  always_comb begin
    mask_ext               = '0;
    mask_ext[NUM_CH-1:0]   = ch_mask;
    first                  = next_ch(mask_ext, -1);
    nxt                    = next_ch(mask_ext, int'(sel));
  end

  // Flag events are suppressed when run drops, matching the abort to IDLE.
  assign rec      = (state == RESULT) && run;
  assign wdog_hit = (state == MEASURE) && run && !cmp.cmp_done && (wdog == wdog_limit);

  assign cmp.ch_sel            = sel;
  assign cmp.cmp_reset         = rst_q;
  assign cmp.cmp_enable        = en_q;
  assign cmp.cmp_timeout_value = tv_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sel        <= '0;
      settle     <= '0;
      wdog       <= '0;
      rst_q      <= 1'b1;
      en_q       <= 1'b0;
      tv_q       <= '0;
      sweep_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      en_q       <= 1'b0;
      sweep_done <= 1'b0;
      if (state != IDLE && !run) begin
        state <= IDLE;
        rst_q <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            rst_q <= 1'b1;
            if (run && first.found) begin
              sel   <= SEL_W'(first.idx);
              state <= SELECT;
              busy  <= 1'b1;
            end
          end
          SELECT: begin
            settle <= SW'(SETTLE_CYCLES - 1);
            state  <= SETTLE;
          end
          SETTLE: begin
            if (settle == '0) begin
              state <= START;
              rst_q <= 1'b0;
              en_q  <= 1'b1;
            end else begin
              settle <= settle - 1'b1;
            end
          end
          START: begin
            tv_q  <= (window < DATA_WIDTH'(MIN_WINDOW)) ? DATA_WIDTH'(MIN_WINDOW) : window;
            wdog  <= '0;
            state <= MEASURE;
          end
          MEASURE: begin
            wdog <= wdog + 1'b1;
            if (cmp.cmp_done) begin
              state <= RESULT;
            end else if (wdog == wdog_limit) begin
              state <= NEXT;
              rst_q <= 1'b1;
            end
          end
          RESULT: begin
            state <= NEXT;
            rst_q <= 1'b1;
          end
          NEXT: begin
            if (nxt.found) begin
              sel   <= SEL_W'(nxt.idx);
              state <= SELECT;
            end else begin
              sweep_done <= 1'b1;
              if (first.found) begin
                sel   <= SEL_W'(first.idx);
                state <= SELECT;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FREQ_MON_SCHED_IRQ_EN
  logic [NUM_CH-1:0] rise;
  logic              rise_q;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = (sel == SEL_W'(i));
    freq_mon_debounce #(.FAIL_THRESH(FAIL_THRESH)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .fail_ev (rec && hit && cmp.cmp_ge),
      .pass_ev (rec && hit && !cmp.cmp_ge),
      .dead_ev (wdog_hit && hit),
      .clear   (fail_clear[i]),
      .fail    (ch_fail[i]),
      .dead    (ch_dead[i])
`ifdef FREQ_MON_SCHED_IRQ_EN
      , .rise  (rise[i])
`endif
    );
  end

`ifdef FREQ_MON_SCHED_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= 1'b0;
      irq    <= 1'b0;
    end else begin
      rise_q <= |rise;
      if (rise_q)         irq <= 1'b1;
      else if (irq_clear) irq <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_freq_monitor_sched.sv
// Directed bench: table of sweep scenarios plus hand sequences for debounce
// patterns, watchdog timing, empty mask, run abort and (optionally) irq.
module tb_freq_monitor_sched;
  logic        clk = 1'b0, reset_n = 1'b0, run = 1'b0;
  logic [3:0]  ch_mask = '0, fail_clear = '0;
  logic [31:0] window = 32'd32;
  logic [23:0] wdog_limit = 24'd100;
  logic [3:0]  ch_fail, ch_dead;
  logic        sweep_done, busy;
`ifdef FREQ_MON_SCHED_IRQ_EN
  logic        irq, irq_clear = 1'b0;
`endif

  freq_monitor_sched_if #(.NUM_CH(4), .DATA_WIDTH(32)) cmp_bus ();

  freq_monitor_sched dut (
    .clk(clk), .reset_n(reset_n), .run(run), .ch_mask(ch_mask), .window(window),
    .wdog_limit(wdog_limit), .fail_clear(fail_clear), .cmp(cmp_bus),
    .ch_fail(ch_fail), .ch_dead(ch_dead), .sweep_done(sweep_done), .busy(busy)
`ifdef FREQ_MON_SCHED_IRQ_EN
    , .irq(irq), .irq_clear(irq_clear)
`endif
  );

  always #5 clk = ~clk;

  // Comparator model: done with per-channel ge 4 cycles after start; hung channels never finish.
  logic [3:0] ge_vec = '0, hang = '0;
  logic       active;
  int         mcnt;
  always @(posedge clk) begin
    if (cmp_bus.cmp_reset) begin
      cmp_bus.cmp_done <= 1'b0;
      cmp_bus.cmp_ge   <= 1'b0;
      active           <= 1'b0;
      mcnt             <= 0;
    end else if (cmp_bus.cmp_enable) begin
      active <= 1'b1;
      mcnt   <= 0;
    end else if (active && !cmp_bus.cmp_done && !hang[cmp_bus.ch_sel]) begin
      mcnt <= mcnt + 1;
      if (mcnt == 3) begin
        cmp_bus.cmp_done <= 1'b1;
        cmp_bus.cmp_ge   <= ge_vec[cmp_bus.ch_sel];
      end
    end
  end

  logic [1:0] visits[$];
  always @(negedge clk) if (cmp_bus.cmp_enable) visits.push_back(cmp_bus.ch_sel);

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_sweeps(input int n);
    for (int k = 0; k < n; k++) begin
      int b = 0;
      do begin @(negedge clk); b++; end while (!sweep_done && b < 600);
      chk("sweep_done_seen", {31'd0, sweep_done}, 32'd1);
    end
  endtask

  task automatic wait_on(input logic [1:0] ch, input logic want_done);
    int b = 0;
    logic hit;
    do begin
      @(negedge clk); b++;
      hit = (cmp_bus.ch_sel == ch) && (want_done ? cmp_bus.cmp_done : cmp_bus.cmp_enable);
    end while (!hit && b < 600);
    chk("wait_event", {31'd0, hit}, 32'd1);
  endtask

  task automatic stop_and_clear();
    run = 1'b0;
    @(negedge clk); fail_clear = 4'hF;
    @(negedge clk); fail_clear = 4'h0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  mask, ge, hang;
    int          sweeps;
    logic [31:0] win;
    logic [7:0]  exp_seq;   // first four visited channels, 2 bits each, LSB first
    int          exp_nvis;
    logic [3:0]  exp_fail, exp_dead;
    logic [31:0] exp_tv;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{4'hF, 4'h0, 4'h0, 2, 32'd32,   8'hE4, 8,  4'h0, 4'h0, 32'd32};
    tbl[1] = '{4'hA, 4'h0, 4'h0, 2, 32'd5,    8'hDD, 4,  4'h0, 4'h0, 32'd16};
    tbl[2] = '{4'h4, 4'h4, 4'h0, 3, 32'd16,   8'h2A, 3,  4'h4, 4'h0, 32'd16};
    tbl[3] = '{4'h4, 4'h4, 4'h0, 2, 32'd15,   8'h0A, 2,  4'h0, 4'h0, 32'd16};
    tbl[4] = '{4'hF, 4'hD, 4'h0, 3, 32'd1000, 8'hE4, 12, 4'hD, 4'h0, 32'd1000};
    tbl[5] = '{4'h2, 4'h0, 4'h2, 1, 32'd32,   8'h01, 1,  4'h0, 4'h2, 32'd32};
    tbl[6] = '{4'h6, 4'h4, 4'h2, 1, 32'd32,   8'h09, 2,  4'h0, 4'h2, 32'd32};

    repeat (2) @(negedge clk);
    chk("rst_ch_sel", 32'(cmp_bus.ch_sel), 32'd0);
    chk("rst_cmp_reset", {31'd0, cmp_bus.cmp_reset}, 32'd1);
    chk("rst_cmp_enable", {31'd0, cmp_bus.cmp_enable}, 32'd0);
    chk("rst_timeout", cmp_bus.cmp_timeout_value, 32'd0);
    chk("rst_fail", {28'd0, ch_fail}, 32'd0);
    chk("rst_dead", {28'd0, ch_dead}, 32'd0);
    chk("rst_sweep_done", {31'd0, sweep_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef FREQ_MON_SCHED_IRQ_EN
    chk("rst_irq", {31'd0, irq}, 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      int n;
      ch_mask = tbl[v].mask; ge_vec = tbl[v].ge; hang = tbl[v].hang; window = tbl[v].win;
      visits.delete();
      run = 1'b1;
      wait_sweeps(tbl[v].sweeps);
      run = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_nvis", v), visits.size(), tbl[v].exp_nvis);
      n = (tbl[v].exp_nvis < 4) ? tbl[v].exp_nvis : 4;
      for (int i = 0; i < n; i++)
        chk($sformatf("v%0d_visit%0d", v, i),
            (i < visits.size()) ? 32'(visits[i]) : 32'hFFFF, 32'(tbl[v].exp_seq[2*i +: 2]));
      chk($sformatf("v%0d_fail", v), {28'd0, ch_fail}, {28'd0, tbl[v].exp_fail});
      chk($sformatf("v%0d_dead", v), {28'd0, ch_dead}, {28'd0, tbl[v].exp_dead});
      chk($sformatf("v%0d_timeout", v), cmp_bus.cmp_timeout_value, tbl[v].exp_tv);
      stop_and_clear();
    end
    hang = '0;

    // ge pattern 1,0,1,1,1 on channel 2: only the final sweep reaches three in a row
    begin
      logic [4:0] pat;
      pat = 5'b11101;
      ch_mask = 4'h4; ge_vec = 4'h0;
      for (int k = 0; k < 5; k++) begin
        ge_vec[2] = pat[k];
        if (k == 0) run = 1'b1;
        wait_sweeps(1);
        if (k >= 2) chk($sformatf("pattern_fail_k%0d", k), {31'd0, ch_fail[2]}, (k == 4) ? 32'd1 : 32'd0);
      end
      stop_and_clear();
    end

    // Watchdog expiry on channel 1 with limit 100, sweep then moves to channel 2
    ch_mask = 4'h6; ge_vec = 4'h0; hang = 4'h2; run = 1'b1;
    wait_on(2'd1, 1'b0);
    repeat (101) @(negedge clk);
    chk("wdog_dead_early", {31'd0, ch_dead[1]}, 32'd0);
    @(negedge clk);
    chk("wdog_dead_set", {31'd0, ch_dead[1]}, 32'd1);
    chk("wdog_cmp_reset", {31'd0, cmp_bus.cmp_reset}, 32'd1);
    @(negedge clk);
    chk("wdog_next_ch", 32'(cmp_bus.ch_sel), 32'd2);
    stop_and_clear();
    hang = '0;

    // Empty mask with run held high never becomes busy
    begin
      logic seen;
      seen = 1'b0;
      ch_mask = 4'h0; run = 1'b1;
      repeat (20) begin @(negedge clk); seen |= busy; end
      chk("mask0_busy", {31'd0, seen}, 32'd0);
      run = 1'b0;
    end

    // Abort during channel 2 measurement: no flag, no sweep_done, count untouched
    begin
      logic sd;
      sd = 1'b0;
      ch_mask = 4'hF; ge_vec = 4'hF; run = 1'b1;
      wait_on(2'd2, 1'b1);
      run = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      repeat (30) begin @(negedge clk); sd |= sweep_done; end
      chk("abort_no_sweep_done", {31'd0, sd}, 32'd0);
      chk("abort_no_fail", {28'd0, ch_fail}, 32'd0);
      ch_mask = 4'h4; run = 1'b1;
      wait_sweeps(2);
      chk("abort_count_kept_2", {31'd0, ch_fail[2]}, 32'd0);
      wait_sweeps(1);
      chk("abort_count_kept_3", {31'd0, ch_fail[2]}, 32'd1);
      stop_and_clear();
    end

`ifdef FREQ_MON_SCHED_IRQ_EN
    // fail_clear coinciding with the third fail: set wins, then irq rises and clears
    ch_mask = 4'h4; ge_vec = 4'h4;
    @(negedge clk); irq_clear = 1'b1;
    @(negedge clk); irq_clear = 1'b0;
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    run = 1'b1;
    wait_sweeps(2);
    wait_on(2'd2, 1'b1);
    @(negedge clk); fail_clear = 4'h4;
    @(negedge clk); fail_clear = 4'h0;
    chk("irq_set_wins_fail", {31'd0, ch_fail[2]}, 32'd1);
    @(negedge clk);
    chk("irq_raised", {31'd0, irq}, 32'd1);
    irq_clear = 1'b1;
    @(negedge clk); irq_clear = 1'b0;
    chk("irq_clear_alone", {31'd0, irq}, 32'd0);
    stop_and_clear();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
